pc_stack: RTL
=============

# pc_stack

Parametrised program counter with a hardware return-address stack, replacing the fixed 4-bit counter in the CPU core. It supports count, jump, subroutine call and return, and drives its value onto the shared system bus under control-word command. The microcode sequencer drives its control inputs; the control-logic debug display reads its status outputs.

## Interface
Parameters:
- WIDTH, 8: address width in bits; must satisfy 1 ≤ WIDTH ≤ BUS_WIDTH.
- BUS_WIDTH, 8: system bus width.
- DEPTH, 4: return-stack entries; must be ≥ 1.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1: system clock; all state changes on its rising edge.
- rst  in  1: synchronous, active-high reset.
- bus  inout  BUS_WIDTH: shared system bus.
- CE  in  1: count enable.
- J  in  1: jump; load the PC from the bus.
- CALL  in  1: push the return address, then load the PC from the bus.
- RET  in  1: pop the PC from the stack.
- CO  in  1: counter out; drive the PC onto the bus.
- pc  out  WIDTH: current PC, for debug display.
- sp  out  clog2(DEPTH+1): number of occupied stack entries.
- stack_full  out  1: high when sp == DEPTH.
- stack_empty  out  1: high when sp == 0.
- err  out  1: sticky stack-fault flag.

## Operation
- Values after reset: pc=0, sp=0, stack_empty=1, stack_full=0, err=0. Stack contents are don't-care. Reset clears err.
- Command priority at each rising edge: rst > RET > CALL > J > CE. Exactly one action is taken per edge. With no command asserted, the PC holds.
- RET, stack not empty: pc ← top entry; sp decrements.
- RET, stack empty: pc holds, sp holds, err ← 1.
- CALL, stack not full: pushes (pc+1) mod 2^WIDTH; pc ← bus[WIDTH-1:0]; sp increments.
- CALL, stack full: no push, pc holds, sp holds, err ← 1.
- J: pc ← bus[WIDTH-1:0]. Upper bus bits are ignored.
- CE: pc ← (pc+1) mod 2^WIDTH. All-ones wraps to 0.
- Lower-priority commands asserted together with a higher one are ignored and raise no error. For example, CE with J loads the bus value only, and a faulting RET with CALL still does not execute the CALL.
- CO: bus[WIDTH-1:0] is driven with pc and bus[BUS_WIDTH-1:WIDTH] is driven with 0. With CO low, all bus bits are high-Z.
- CO with J or CALL in the same cycle is legal: the PC loads its own current value (for CALL, the push still occurs).
- err stays set until rst.

## Timing
- CO to bus is combinational: same-cycle drive and release, no registered enable.
- The bus is sampled at the rising edge for J and CALL. The source must hold the value through the setup window of that edge.
- pc, sp, stack_full, stack_empty and err update on the edge that executes the command, and are visible in the following cycle.
- Latency is one cycle for every command. Back-to-back CALL or RET on consecutive cycles are supported at the full rate.
- The push and the PC load of a CALL occur on the same edge. The pushed value is the pre-edge pc+1.
- rst asserted mid-sequence (for example between a CALL and its RET) discards the stack on that edge. Any command asserted in that cycle is ignored.
- stack_full and stack_empty are decoded combinationally from registered sp, so they carry no extra latency.

## Structure
- Shared header pc_stack_defs.vh holds:
  - the command-priority encoding (CMD_RST, CMD_RET, CMD_CALL, CMD_JUMP, CMD_COUNT, CMD_HOLD);
  - the clog2 macro used for the sp width.
- Sub-module pc_return_stack: LIFO of DEPTH × WIDTH entries.
  - Inputs: push, pop, push_data. Outputs: top, sp, full, empty.
  - It performs no fault detection; the parent gates push and pop and sets err.
- Bus drive reuses the existing tri_state_buffer, instantiated as an array across BUS_WIDTH bits.
- Top level contains the priority decode, the PC register, the incrementer and the err flag.

## Test plan
With default parameters (WIDTH=8, BUS_WIDTH=8, DEPTH=4) unless noted.
- Reset, then CE for 260 cycles → pc reads 0→255, wraps to 0, ends at 4; bus stays high-Z throughout with CO low.
- pc=0x10, bus=0x80, CALL → pc=0x80, sp=1. Then RET → pc=0x11, sp=0, stack_empty=1.
- Four nested CALLs from pc=0x01, 0x21, 0x41, 0x61 → sp=4 and stack_full=1. A fifth CALL → pc unchanged, err=1. Four RETs then return 0x62, 0x42, 0x22, 0x02.
- RET on an empty stack → pc unchanged, sp=0, err=1. err remains 1 through subsequent valid commands until rst.
- CE+J+CO with pc=0x33 → bus reads 0x33 and pc stays 0x33. Then RET+CALL with sp=1 → RET only executes and sp=0.
- Rerun with WIDTH=4, BUS_WIDTH=8, and with CO high, pc=0xF:
  - bus reads 0x0F;
  - J with bus=0xA7 → pc=0x7;
  - CE from 0xF → pc=0x0.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program counter with return-address stack:
// the command-priority encoding and the decoder that applies it.
package pc_stack_pkg;

    // One action per edge; the encoding lists commands from lowest to
    // highest priority.
    typedef enum logic [2:0] {
        CMD_HOLD  = 3'd0,
        CMD_COUNT = 3'd1,
        CMD_JUMP  = 3'd2,
        CMD_CALL  = 3'd3,
        CMD_RET   = 3'd4,
        CMD_RST   = 3'd5
    } cmd_e;

    // Width of a counter that has to hold the values 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Priority: rst > RET > CALL > J > CE. Lower-priority requests asserted
    // alongside a higher one are dropped here, so they can never fault.
    function automatic cmd_e decode_cmd(input logic rst, input logic ret,
                                        input logic call, input logic j,
                                        input logic ce);
        if (rst)       return CMD_RST;
        else if (ret)  return CMD_RET;
        else if (call) return CMD_CALL;
        else if (j)    return CMD_JUMP;
        else if (ce)   return CMD_COUNT;
        else           return CMD_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_return_stack.sv
// LIFO of return addresses. No fault detection here: the parent never
// pushes when full or pops when empty, and owns the error flag.
module pc_return_stack import pc_stack_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [sp_width(DEPTH)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int SPW = sp_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Occupancy counter; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (rst)       sp <= '0;
        else if (push) sp <= sp + 1'b1;
        else if (pop)  sp <= sp - 1'b1;
    end

    // Entry storage: a push writes the slot just above the current top.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (sp == SPW'(i))) mem[i] <= push_data;
        end
    end

    // Top-of-stack read; a mux over slots avoids indexing past DEPTH.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) top = mem[i];
        end
    end

    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);

endmodule

// File: rtl/tri_state_buffer.sv
// Single-bit tri-state driver onto the shared system bus.
module tri_state_buffer (
    input  logic a,
    input  logic en,
    output wire  y
);

    assign y = en ? a : 1'bz;

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack. Supports count,
// jump, call and return, and drives its value onto the system bus on CO.
module pc_stack import pc_stack_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    inout  wire  [BUS_WIDTH-1:0]         bus,
    input  logic                         CE,
    input  logic                         J,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic                         CO,
    output logic [WIDTH-1:0]             pc,
    output logic [sp_width(DEPTH)-1:0]   sp,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         err
);

    cmd_e                 cmd;
    logic [WIDTH-1:0]     pc_inc;
    logic [WIDTH-1:0]     bus_in;
    logic [WIDTH-1:0]     stack_top;
    logic [BUS_WIDTH-1:0] bus_drive;
    logic                 push;
    logic                 pop;
    logic                 fault;

    assign cmd    = decode_cmd(rst, RET, CALL, J, CE);
    assign pc_inc = pc + 1'b1;
    assign bus_in = bus[WIDTH-1:0];

    // Stack moves only for non-faulting CALL/RET; faults only set err.
    assign push  = (cmd == CMD_CALL) && !stack_full;
    assign pop   = (cmd == CMD_RET)  && !stack_empty;
    assign fault = ((cmd == CMD_CALL) && stack_full) ||
                   ((cmd == CMD_RET)  && stack_empty);

    // PC register: one action per edge in priority order; faults hold.
    always_ff @(posedge clk) begin
        case (cmd)
            CMD_RST:   pc <= '0;
            CMD_RET:   if (!stack_empty) pc <= stack_top;
            CMD_CALL:  if (!stack_full)  pc <= bus_in;
            CMD_JUMP:  pc <= bus_in;
            CMD_COUNT: pc <= pc_inc;
            default:   pc <= pc;
        endcase
    end

    // Sticky stack-fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)        err <= 1'b0;
        else if (fault) err <= 1'b1;
    end

    // The pushed return address is the pre-edge pc+1.
    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Upper bus bits are driven with zero while CO is high.
    assign bus_drive = BUS_WIDTH'(pc);

    for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_bus_buf
        tri_state_buffer u_buf (
            .a  (bus_drive[b]),
            .en (CO),
            .y  (bus[b])
        );
    end

endmodule
